// File: rtl/bus_ctrl_pkg.sv
// bus_ctrl_pkg: shared types, speed encodings and width helper for the bus-cycle controller
package bus_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;
  localparam logic SPEED_C7M = 1'b1;
  localparam logic SPEED_C14M = 1'b0;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/bus_cycle_ctrl_wait_counter.sv
// wait_counter: loadable wait-state down-counter, done flags the last wait cycle
//   clk, rst_n     clock, async active-low reset
//   load, val      load the wait-state count
//   en             decrement by one
//   done           count equals 1
module wait_counter #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] val,
  output logic             done
);
  logic [WIDTH-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (load) cnt <= val;
    else if (en) cnt <= cnt - WIDTH'(1);
  assign done = cnt == WIDTH'(1);
endmodule

// File: rtl/bus_cycle_ctrl.sv
// bus_cycle_ctrl: 68000 bus-cycle controller (local DTACK wait states, speed switch, DMA arbitration)
//   C14M, RESET_n        clock, async active-low reset
//   SW1                  raw speed switch
//   AS_CPU_n, AS_MB_IN_n CPU strobe, motherboard strobe from the pad
//   DTACK_MB_n, M6800_DTACK_n external DTACK sources
//   BG_n, BGACK_n, HALT_n arbitration inputs
//   REGION_HIT, REGION_WS per-region decode hit and wait states
//   DTACK_n, AS_n, AS_MB_n, AS_MB_OE, DMA_ACTIVE, CPU_SPEED, BERR_n outputs
// Define BUS_TIMEOUT_EN to add the bus-error timeout counter.
module bus_cycle_ctrl
  import bus_ctrl_pkg::*;
#(
  parameter int NUM_REGIONS    = 2,
  parameter int WS_WIDTH       = 3,
  parameter int DEFAULT_SPEED  = 1,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                            C14M,
  input  logic                            RESET_n,
  input  logic                            SW1,
  input  logic                            AS_CPU_n,
  input  logic                            AS_MB_IN_n,
  input  logic                            DTACK_MB_n,
  input  logic                            M6800_DTACK_n,
  input  logic                            BG_n,
  input  logic                            BGACK_n,
  input  logic                            HALT_n,
  input  logic [NUM_REGIONS-1:0]          REGION_HIT,
  input  logic [NUM_REGIONS*WS_WIDTH-1:0] REGION_WS,
  output logic                            DTACK_n,
  output logic                            AS_n,
  output logic                            AS_MB_n,
  output logic                            AS_MB_OE,
  output logic                            DMA_ACTIVE,
  output logic                            CPU_SPEED,
  output logic                            BERR_n
);
  localparam logic DEF_SPEED = (DEFAULT_SPEED != 0) ? SPEED_C7M : SPEED_C14M;
  state_t state, state_nxt;
  logic fast_n, fast_n_nxt, load, en, done;
  logic as_sel, bus_idle, dmareq_n, dma_nxt;
  logic [1:0] sw_sync;
  logic [WS_WIDTH-1:0] hit_ws;
  assign as_sel = DMA_ACTIVE ? AS_MB_IN_n : AS_CPU_n;
  assign bus_idle = as_sel & DTACK_n;
  assign dma_nxt = !(dmareq_n & BGACK_n & HALT_n);
  // reverse scan so the lowest-index hit wins
  always_comb begin
    hit_ws = '0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--)
      if (REGION_HIT[i]) hit_ws = REGION_WS[i*WS_WIDTH +: WS_WIDTH];
  end
  wait_counter #(.WIDTH(WS_WIDTH)) u_wait (
    .clk  (C14M),
    .rst_n(RESET_n),
    .load (load),
    .en   (en),
    .val  (hit_ws),
    .done (done)
  );
  always_ff @(posedge C14M or negedge RESET_n)
    if (!RESET_n) begin
      state  <= IDLE;
      fast_n <= 1'b1;
    end else begin
      state  <= state_nxt;
      fast_n <= fast_n_nxt;
    end
  // a DMA handover mid-cycle swaps the strobe source, so the local cycle is dropped
  always_comb begin
    state_nxt  = state;
    fast_n_nxt = fast_n;
    load       = 1'b0;
    en         = 1'b0;
    if (dma_nxt != DMA_ACTIVE && state != IDLE) begin
      state_nxt  = IDLE;
      fast_n_nxt = 1'b1;
    end else
      case (state)
        IDLE:
          if (!as_sel && |REGION_HIT) begin
            load       = 1'b1;
            state_nxt  = (hit_ws == '0) ? ACK : WAIT;
            fast_n_nxt = hit_ws != '0;
          end
        WAIT:
          if (as_sel) begin
            state_nxt  = IDLE;
            fast_n_nxt = 1'b1;
          end else begin
            en = 1'b1;
            if (done) begin
              state_nxt  = ACK;
              fast_n_nxt = 1'b0;
            end
          end
        ACK:
          if (as_sel) begin
            state_nxt  = IDLE;
            fast_n_nxt = 1'b1;
          end
        default: begin
          state_nxt  = IDLE;
          fast_n_nxt = 1'b1;
        end
      endcase
  end
  always_comb begin
    DTACK_n  = fast_n & DTACK_MB_n & M6800_DTACK_n;
    AS_MB_OE = !DMA_ACTIVE;
  end
  always_ff @(posedge C14M or negedge RESET_n)
    if (!RESET_n) begin
      AS_n       <= 1'b1;
      AS_MB_n    <= 1'b1;
      DMA_ACTIVE <= 1'b0;
      CPU_SPEED  <= DEF_SPEED;
      sw_sync    <= {2{DEF_SPEED}};
      dmareq_n   <= 1'b1;
    end else begin
      AS_n       <= as_sel;
      AS_MB_n    <= AS_CPU_n;
      DMA_ACTIVE <= dma_nxt;
      sw_sync    <= {sw_sync[0], SW1};
      CPU_SPEED  <= bus_idle ? sw_sync[1] : CPU_SPEED;
      dmareq_n   <= BG_n ? 1'b1 : (bus_idle ? 1'b0 : dmareq_n);
    end
`ifdef BUS_TIMEOUT_EN
  localparam int TW = clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt, to_nxt;
  assign to_nxt = (as_sel || !DTACK_n) ? '0 :
                  (to_cnt == TW'(TIMEOUT_CYCLES)) ? to_cnt : to_cnt + TW'(1);
  always_ff @(posedge C14M or negedge RESET_n)
    if (!RESET_n) begin
      to_cnt <= '0;
      BERR_n <= 1'b1;
    end else begin
      to_cnt <= to_nxt;
      BERR_n <= as_sel ? 1'b1 : (to_nxt == TW'(TIMEOUT_CYCLES)) ? 1'b0 : BERR_n;
    end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign BERR_n = 1'b1;
`endif
endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// tb_bus_cycle_ctrl: directed and randomized checks of bus_cycle_ctrl against a behavioural model
module tb_bus_cycle_ctrl;
  import bus_ctrl_pkg::*;
  localparam int NR = 2, WSW = 3, TO = 8;
  logic clk = 0, rst_n = 0, sw1 = 1, as_cpu_n = 1, as_mb_in_n = 1, dtack_mb_n = 1, m6800_dtack_n = 1;
  logic bg_n = 1, bgack_n = 1, halt_n = 1;
  logic [NR-1:0] region_hit = '0;
  logic [NR*WSW-1:0] region_ws = '0;
  logic dtack_n, as_n, as_mb_n, as_mb_oe, dma_active, cpu_speed, berr_n;
  int total = 0, bad = 0;
  int m_phase = 0, m_elapsed = 0, m_target = 0, m_tcnt = 0;
  bit m_fast = 1, m_speed = 1, m_req = 1, m_dma = 0, m_as = 1, m_asmb = 1, m_berr = 1;
  bit [1:0] m_sync = 2'b11;

  always #5 clk = ~clk;

  bus_cycle_ctrl #(.NUM_REGIONS(NR), .WS_WIDTH(WSW), .DEFAULT_SPEED(1), .TIMEOUT_CYCLES(TO)) dut (
    .C14M(clk), .RESET_n(rst_n), .SW1(sw1), .AS_CPU_n(as_cpu_n), .AS_MB_IN_n(as_mb_in_n),
    .DTACK_MB_n(dtack_mb_n), .M6800_DTACK_n(m6800_dtack_n), .BG_n(bg_n), .BGACK_n(bgack_n),
    .HALT_n(halt_n), .REGION_HIT(region_hit), .REGION_WS(region_ws), .DTACK_n(dtack_n),
    .AS_n(as_n), .AS_MB_n(as_mb_n), .AS_MB_OE(as_mb_oe), .DMA_ACTIVE(dma_active),
    .CPU_SPEED(cpu_speed), .BERR_n(berr_n)
  );

  function automatic logic [6:0] got_vec();
    return {dtack_n, as_n, as_mb_n, as_mb_oe, dma_active, cpu_speed, berr_n};
  endfunction

  function automatic logic [6:0] exp_vec();
    return {m_fast & dtack_mb_n & m6800_dtack_n, m_as, m_asmb, !m_dma, m_dma, m_speed, m_berr};
  endfunction

  // Model: a local cycle starts when the strobe is seen low with a hit, and DTACK is
  // owed WS edges after that sample; it is withdrawn the edge the strobe is seen high.
  task automatic step();
    bit sel, dt, idle, dma_n, found;
    int ws;
    sel = m_dma ? as_mb_in_n : as_cpu_n;
    dt = m_fast & dtack_mb_n & m6800_dtack_n;
    idle = sel & dt;
    dma_n = !(m_req & bgack_n & halt_n);
    found = 0;
    ws = 0;
    for (int i = 0; i < NR; i++)
      if (!found && region_hit[i]) begin
        found = 1;
        ws = int'(region_ws[i*WSW +: WSW]);
      end
    if (dma_n != m_dma && m_phase != 0) begin
      m_phase = 0;
      m_fast = 1;
    end else if (m_phase == 0) begin
      if (!sel && found) begin
        if (ws == 0) begin
          m_phase = 2;
          m_fast = 0;
        end else begin
          m_phase = 1;
          m_elapsed = 0;
          m_target = ws;
        end
      end
    end else if (sel) begin
      m_phase = 0;
      m_fast = 1;
    end else if (m_phase == 1) begin
      m_elapsed++;
      if (m_elapsed == m_target) begin
        m_phase = 2;
        m_fast = 0;
      end
    end
    if (idle) m_speed = m_sync[1];
    m_sync = {m_sync[0], sw1};
    if (bg_n) m_req = 1;
    else if (idle) m_req = 0;
    m_dma = dma_n;
    m_as = sel;
    m_asmb = as_cpu_n;
`ifdef BUS_TIMEOUT_EN
    if (sel || !dt) m_tcnt = 0;
    else if (m_tcnt < TO) m_tcnt++;
    if (sel) m_berr = 1;
    else if (m_tcnt == TO) m_berr = 0;
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    #12;
    total++;
    if (got_vec() !== 7'b1111011) begin
      bad++;
      $display("FAIL reset_hold outputs got=%b exp=%b", got_vec(), 7'b1111011);
    end
    @(negedge clk);
    rst_n = 1;
    step();
    total++;
    if (got_vec() !== 7'b1111011 || dut.state !== IDLE) begin
      bad++;
      $display("FAIL reset_release outputs got=%b exp=%b", got_vec(), 7'b1111011);
    end
  endtask

  task automatic test_ws0();
    region_hit = 2'b01;
    region_ws = '0;
    as_cpu_n = 0;
    #1;
    total++;
    if (dtack_n !== 1'b1) begin
      bad++;
      $display("FAIL ws0_pre dtack got=%b exp=1", dtack_n);
    end
    for (int j = 0; j < 4; j++) begin
      if (j == 3) as_cpu_n = 1;
      step();
      total++;
      if (dtack_n !== (j == 3) || got_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL ws0 edge%0d got=%b exp=%b dtack_req=%b", j, got_vec(), exp_vec(), j == 3);
      end
    end
    region_hit = '0;
  endtask

  task automatic test_priority();
    region_hit = 2'b11;
    region_ws = {3'd0, 3'd3};
    as_cpu_n = 0;
    for (int j = 0; j < 4; j++) begin
      step();
      total++;
      if (dtack_n !== (j != 3) || got_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL priority edge%0d got=%b exp=%b dtack_req=%b", j, got_vec(), exp_vec(), j != 3);
      end
    end
    as_cpu_n = 1;
    region_hit = '0;
    step();
    step();
  endtask

  task automatic test_abort();
    region_hit = 2'b01;
    region_ws = {3'd0, 3'd5};
    as_cpu_n = 0;
    for (int j = 0; j < 4; j++) begin
      if (j == 2) as_cpu_n = 1;
      step();
      total++;
      if (dtack_n !== 1'b1 || got_vec() !== exp_vec() || (j >= 2 && dut.state !== IDLE)) begin
        bad++;
        $display("FAIL abort edge%0d got=%b exp=%b state=%0d", j, got_vec(), exp_vec(), dut.state);
      end
    end
    region_hit = '0;
  endtask

  task automatic test_speed();
    region_hit = '0;
    as_cpu_n = 0;
    sw1 = 0;
    for (int j = 0; j < 5; j++) begin
      step();
      total++;
      if (cpu_speed !== 1'b1 || got_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL speed_hold edge%0d got=%b exp=%b", j, got_vec(), exp_vec());
      end
    end
    as_cpu_n = 1;
    step();
    total++;
    if (cpu_speed !== 1'b0 || got_vec() !== exp_vec()) begin
      bad++;
      $display("FAIL speed_idle got=%b exp=%b speed_req=0", got_vec(), exp_vec());
    end
    sw1 = 1;
    for (int j = 0; j < 3; j++) begin
      step();
      total++;
      if (cpu_speed !== (j == 2) || got_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL speed_sync edge%0d got=%b exp=%b speed_req=%b", j, got_vec(), exp_vec(), j == 2);
      end
    end
  endtask

  task automatic test_dma();
    region_hit = 2'b01;
    region_ws = '0;
    as_cpu_n = 0;
    step();
    bg_n = 0;
    for (int j = 0; j < 3; j++) begin
      step();
      total++;
      if (dma_active !== 1'b0 || got_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL dma_wait edge%0d got=%b exp=%b", j, got_vec(), exp_vec());
      end
    end
    as_cpu_n = 1;
    region_hit = '0;
    for (int j = 0; j < 4; j++) begin
      step();
      total++;
      if (dma_active !== (j >= 2) || as_mb_oe !== (j < 2) || got_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL dma_grant edge%0d got=%b exp=%b dma_req=%b", j, got_vec(), exp_vec(), j >= 2);
      end
    end
    for (int j = 0; j < 4; j++) begin
      as_mb_in_n = j[0];
      step();
      total++;
      if (as_n !== j[0] || got_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL dma_strobe edge%0d got=%b exp=%b as_req=%b", j, got_vec(), exp_vec(), j[0]);
      end
    end
    bg_n = 1;
    for (int j = 0; j < 2; j++) begin
      step();
      total++;
      if (dma_active !== (j == 0) || got_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL dma_release edge%0d got=%b exp=%b dma_req=%b", j, got_vec(), exp_vec(), j == 0);
      end
    end
  endtask

  task automatic test_timeout();
    bit req;
    region_hit = '0;
    dtack_mb_n = 1;
    as_cpu_n = 0;
    for (int j = 1; j <= 10; j++) begin
      if (j == 10) as_cpu_n = 1;
`ifdef BUS_TIMEOUT_EN
      req = !(j >= TO && j < 10);
`else
      req = 1'b1;
`endif
      step();
      total++;
      if (berr_n !== req || got_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL timeout edge%0d got=%b exp=%b berr_req=%b", j, got_vec(), exp_vec(), req);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(3) == 0) as_cpu_n = ~as_cpu_n;
      if ($urandom_range(3) == 0) as_mb_in_n = ~as_mb_in_n;
      if ($urandom_range(15) == 0) bg_n = ~bg_n;
      if ($urandom_range(9) == 0) sw1 = ~sw1;
      bgack_n = $urandom_range(19) != 0;
      halt_n = $urandom_range(29) != 0;
      dtack_mb_n = $urandom_range(7) != 0;
      m6800_dtack_n = $urandom_range(15) != 0;
      region_hit = NR'($urandom);
      region_ws = (NR*WSW)'($urandom);
      step();
      total++;
      if (got_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL random cycle%0d got=%b exp=%b", n, got_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_ws0();
    test_priority();
    test_abort();
    test_speed();
    test_dma();
    test_timeout();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bus_cycle_ctrl.md
Name: bus_cycle_ctrl

Overview:
- Parametrised 68000 bus-cycle controller for the accelerator top level.
- Generates local DTACK for N address regions, each with programmable wait states, merged with motherboard and 6800 DTACK.
- Hot-switches CPU clock speed only while the bus is idle.
- Performs BG/BGACK/HALT DMA arbitration and selects between the CPU and motherboard address strobes.

Parameters:
- NUM_REGIONS, 2, number of local decode regions (1..8).
- WS_WIDTH, 3, bit width of each region's wait-state count.
- DEFAULT_SPEED, 1, CPU_SPEED value after reset (1 = C7M, 0 = C14M).
- TIMEOUT_CYCLES, 255, C14M cycles before bus error (used only with BUS_TIMEOUT_EN).

Ports:
- C14M  in  1  sole clock; all state updates on its rising edge.
- RESET_n  in  1  asynchronous active-low reset.
- SW1  in  1  raw speed switch (asynchronous).
- AS_CPU_n  in  1  CPU address strobe.
- AS_MB_IN_n  in  1  motherboard address strobe sampled from the pad.
- DTACK_MB_n  in  1  motherboard DTACK.
- M6800_DTACK_n  in  1  DTACK from the 6800 bus block.
- BG_n  in  1  bus grant.
- BGACK_n  in  1  bus grant acknowledge.
- HALT_n  in  1  halt.
- REGION_HIT  in  NUM_REGIONS  per-region decode hit, valid while the strobe is low.
- REGION_WS  in  NUM_REGIONS*WS_WIDTH  wait states for each region; region i occupies bits [i*WS_WIDTH +: WS_WIDTH].
- DTACK_n  out  1  merged DTACK to the pad driver.
- AS_n  out  1  registered selected address strobe.
- AS_MB_n  out  1  value driven onto the motherboard AS.
- AS_MB_OE  out  1  1 = drive AS_MB_n, 0 = release the pad (DMA).
- DMA_ACTIVE  out  1  another master owns the bus.
- CPU_SPEED  out  1  clock-mux select.
- BERR_n  out  1  bus error.

Behaviour:
- Reset values: DTACK_n=1, AS_n=1, AS_MB_n=1, AS_MB_OE=1, DMA_ACTIVE=0, CPU_SPEED=DEFAULT_SPEED, BERR_n=1, state=IDLE, SW1 synchroniser=DEFAULT_SPEED.
- Selected strobe: as_sel = DMA_ACTIVE ? AS_MB_IN_n : AS_CPU_n. It is registered into AS_n every cycle.
- AS_MB_n is registered from AS_CPU_n. AS_MB_OE = !DMA_ACTIVE.
- fast_n is a registered signal driven by the state machine.
- DTACK_n = fast_n & DTACK_MB_n & M6800_DTACK_n. This final AND is combinational.
- bus_idle = as_sel & DTACK_n.
- State machine, states IDLE, WAIT, ACK:
  - IDLE: when as_sel=0 and any REGION_HIT bit is set, pick the lowest-index hit region and load cnt=its WS.
  - IDLE with WS=0: go to ACK; fast_n goes low on the same edge (1-edge latency from the first low-strobe sample).
  - IDLE with WS>0: go to WAIT.
  - IDLE with no hit: stay in IDLE; DTACK comes from the external sources only.
  - WAIT: cnt decrements every cycle. When cnt==1, go to ACK with fast_n=0. Total latency from the sample edge is WS+1 edges, so DTACK_n is low after edge k+WS.
  - WAIT with as_sel=1: abort to IDLE, fast_n=1.
  - ACK: hold fast_n=0 until as_sel=1, then go to IDLE with fast_n=1 on that edge.
  - REGION_HIT and REGION_WS are ignored outside IDLE.
- Speed switch:
  - SW1 passes through a 2-flop synchroniser.
  - CPU_SPEED loads the synchronised value only on cycles where bus_idle=1. Otherwise it holds.
- Arbitration:
  - dmareq_n is cleared when BG_n=0 and bus_idle=1.
  - dmareq_n is set when BG_n=1.
  - DMA_ACTIVE = registered !(dmareq_n & BGACK_n & HALT_n).
  - A switch of as_sel caused by a DMA_ACTIVE change while the state is not IDLE forces IDLE and fast_n=1.
- Simultaneous BG_n falling and an AS_CPU_n falling edge: arbitration waits for the CPU cycle to complete (bus_idle required).

Optional Feature:
- BUS_TIMEOUT_EN defined:
  - A counter of width clog2(TIMEOUT_CYCLES+1) clears while as_sel=1 or DTACK_n=0, and increments otherwise.
  - On reaching TIMEOUT_CYCLES, BERR_n=0 until as_sel=1, then BERR_n=1 on that edge.
  - The counter saturates and does not wrap.
- BUS_TIMEOUT_EN undefined: BERR_n is tied to 1 and no counter logic exists.

Decomposition:
- Package bus_ctrl_pkg holds:
  - the state enum (IDLE/WAIT/ACK);
  - the speed encodings SPEED_C7M=1 and SPEED_C14M=0;
  - the clog2 function used for counter widths.
- One sub-module: wait_counter. It is a loadable WS_WIDTH-bit down-counter with load, enable and a done==1 flag, instantiated once.
- Priority select and arbitration stay in the top level.

Test Plan:
- Region 0 hit, WS=0, AS_CPU_n low at edge k: DTACK_n=0 after edge k, returns to 1 the edge after AS_CPU_n rises.
- Regions 0 and 1 both hit, WS0=3, WS1=0: region 0 wins, DTACK_n low after edge k+3.
- WS=5 and AS_CPU_n rises at k+2: DTACK_n never asserts, state=IDLE at k+3.
- SW1 toggles mid-cycle (AS low, DTACK high): CPU_SPEED unchanged until the first bus_idle cycle after the synchroniser delay.
- BG_n=0 during an active cycle: DMA_ACTIVE stays 0 until AS_CPU_n=1; it rises 2 edges later, AS_MB_OE=0, AS_n follows AS_MB_IN_n.
- With BUS_TIMEOUT_EN and TIMEOUT_CYCLES=8, no hit and DTACK_MB_n=1: BERR_n=0 after 8 low-strobe cycles, released when AS rises.
